// File: rtl/fifo_frame_writer_if.sv
// Bundle between the frame writer and the write side of the dual-clock FIFO.
// Handshake: fifo_wr_en is valid, (~full & ~wr_rst_busy) is ready; a word moves on the wr_clk edge where fifo_wr_en=1, and fifo_din is held until it moves.
interface fifo_frame_writer_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 9
) ();
    logic              enable;
    logic              wr_rst_busy;
    logic              full;
    logic [CNT_W-1:0]  wr_data_count;
    logic [DATA_W-1:0] fifo_din;
    logic              fifo_wr_en;
    logic              busy;
    logic [15:0]       frame_cnt;
    logic [15:0]       stall_cnt;
    logic [2:0]        state_dbg;

    modport master (
        input  enable, wr_rst_busy, full, wr_data_count,
        output fifo_din, fifo_wr_en, busy, frame_cnt, stall_cnt, state_dbg
    );

    modport slave (
        output enable, wr_rst_busy, full, wr_data_count,
        input  fifo_din, fifo_wr_en, busy, frame_cnt, stall_cnt, state_dbg
    );
endinterface

// File: rtl/fifo_frame_writer.sv
// Framed burst source for the FIFO write port: header, incrementing payload, checksum.
// Waits for enough free space that a whole frame fits before starting one.
module fifo_frame_writer #(
    parameter int                DATA_W     = 16,
    parameter int                CNT_W      = 9,
    parameter int                FIFO_DEPTH = 512,
    parameter int                START_DLY  = 80,
    parameter int                BURST_LEN  = 64,
    parameter int                GAP_CYCLES = 16,
    parameter logic [DATA_W-1:0] HDR_WORD   = 16'hA5A5
) (
    input logic                 wr_clk,
    input logic                 fifo_rst_n,
    fifo_frame_writer_if.master bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_HDR  = 3'd2;
    localparam logic [2:0] ST_PAY  = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;
    localparam logic [2:0] ST_GAP  = 3'd5;

    localparam int         THRESH   = FIFO_DEPTH - BURST_LEN - 2;
    localparam logic [7:0] DLY_LAST = 8'(START_DLY - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [15:0] PAY_LAST = 16'(BURST_LEN - 1);
    localparam bit         NO_GAP   = (GAP_CYCLES == 0);

    logic [2:0]        state_q, state_d;
    logic [7:0]        dly_q, dly_d;
    logic [7:0]        gap_q, gap_d;
    logic [15:0]       pay_q, pay_d;
    logic [DATA_W-1:0] seq_q, seq_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [15:0]       frame_q, frame_d;
    logic [15:0]       stall_q, stall_d;

    logic in_frame;
    logic acc;
    logic fits;

    assign in_frame = (state_q == ST_HDR) || (state_q == ST_PAY) || (state_q == ST_CSUM);
    assign acc      = in_frame && !bus.full && !bus.wr_rst_busy;
    // Start only when header, payload and checksum all fit in the free space.
    assign fits     = {{(32-CNT_W){1'b0}}, bus.wr_data_count} <= $unsigned(THRESH);

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        gap_d   = gap_q;
        pay_d   = pay_q;
        seq_d   = seq_q;
        csum_d  = csum_q;
        frame_d = frame_q;
        stall_d = stall_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.wr_rst_busy) begin
                    dly_d = 8'd0;
                end else if (dly_q == DLY_LAST) begin
                    dly_d   = 8'd0;
                    state_d = ST_WAIT;
                end else begin
                    dly_d = dly_q + 8'd1;
                end
            end
            ST_WAIT: begin
                if (bus.enable && !bus.wr_rst_busy && fits) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (acc) begin
                    csum_d  = '0;
                    pay_d   = 16'd0;
                    state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                if (acc) begin
                    csum_d = csum_q + seq_q;
                    seq_d  = seq_q + 1'b1;
                    pay_d  = pay_q + 16'd1;
                    if (pay_q == PAY_LAST) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (acc) begin
                    frame_d = frame_q + 16'd1;
                    state_d = NO_GAP ? ST_WAIT : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = 8'd0;
                    state_d = ST_WAIT;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Stall counter saturates so a long backpressure episode never aliases to a small count.
        if (in_frame && !acc && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge wr_clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            state_q <= ST_IDLE;
            dly_q   <= 8'd0;
            gap_q   <= 8'd0;
            pay_q   <= 16'd0;
            seq_q   <= DATA_W'(1);
            csum_q  <= '0;
            frame_q <= 16'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            gap_q   <= gap_d;
            pay_q   <= pay_d;
            seq_q   <= seq_d;
            csum_q  <= csum_d;
            frame_q <= frame_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_HDR:  bus.fifo_din = HDR_WORD;
            ST_PAY:  bus.fifo_din = seq_q;
            ST_CSUM: bus.fifo_din = csum_q;
            default: bus.fifo_din = '0;
        endcase
    end

    assign bus.fifo_wr_en = acc;
    assign bus.busy       = in_frame;
    assign bus.frame_cnt  = frame_q;
    assign bus.stall_cnt  = stall_q;
    assign bus.state_dbg  = state_q;
endmodule
